falco_fetch_queue: RTL
======================

FALCO_FETCH_QUEUE -- requirements
Module: falco_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32 (`SIZE_OF_THE_BUS`), is the fetch address and PC width.
REQ-002 Parameter QDEPTH, default 8, is the queue depth in 32-bit instructions; power of two, at least 4.
REQ-003 Parameter RESET_PC, default 0, is the first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  redirect request from the backend.
REQ-007 flush_pc  in  ADDR_W  redirect target; bits [1:0] ignored.
REQ-008 p_strobe  out  1  fetch request to instruction memory; one-cycle pulse.
REQ-009 instr0_addr  out  ADDR_W  fetch address; bits [1:0] always 0.
REQ-010 resp_ready  in  1  instruction memory response valid.
REQ-011 raw_instr0 / raw_instr1  in  32 each  instruction at addr / addr+4.
REQ-012 instr0_valid / instr1_valid  in  1 each  per-slot validity of the response.
REQ-013 out_valid0 / out_valid1  out  1 each  queue head / head+1 present.
REQ-014 out_instr0 / out_instr1  out  32 each  instruction at head / head+1.
REQ-015 out_pc0 / out_pc1  out  ADDR_W each  PC of head / head+1.
REQ-016 deq_count  in  2  number of instructions decode consumes this cycle (0..2).
REQ-017 q_count  out  $clog2(QDEPTH)+1  current queue occupancy.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and DRAIN.
REQ-019 IDLE -> WAIT SHALL occur when flush=0 and the free slot count (QDEPTH - q_count, before this cycle's dequeue) is at least 2; the next cycle then has p_strobe=1 and instr0_addr=fetch_pc.
REQ-020 p_strobe SHALL be registered and high for exactly one cycle per request; at most one request SHALL be outstanding.
REQ-021 In WAIT, resp_ready is sampled every edge; when it is high, the block SHALL push raw_instr0 (if instr0_valid) then raw_instr1 (if instr1_valid) with PCs fetch_pc and fetch_pc+4, set fetch_pc += 8 (mod 2^ADDR_W), and go to IDLE.
REQ-022 Pushed entries SHALL appear on the out_* ports the cycle after the capture edge.
REQ-023 resp_ready SHALL be ignored in IDLE and DRAIN except as stated in REQ-027.
REQ-024 Ports: out_valid0 = (q_count >= 1); out_valid1 = (q_count >= 2); out_* = the entries at head and head+1.
REQ-025 The block SHALL dequeue min(deq_count, q_count) entries; deq_count=3 SHALL be treated as 2.
REQ-026 On a simultaneous push and pop, q_count SHALL update as q_count + pushed - popped; pointers SHALL wrap modulo QDEPTH.
REQ-027 flush=1 SHALL take priority over push and pop in the same cycle:
- queue emptied (q_count=0 next cycle);
- fetch_pc <= {flush_pc[ADDR_W-1:2], 2'b00};
- from WAIT with resp_ready=0: go to DRAIN;
- otherwise: go to IDLE.
REQ-028 DRAIN SHALL discard the next response (resp_ready=1) without a push, then go to IDLE; a flush in DRAIN SHALL only update fetch_pc.
REQ-029 No entry SHALL ever be pushed when the queue is full; overflow is impossible by REQ-019.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously set: state=IDLE, fetch_pc=RESET_PC, p_strobe=0, instr0_addr=RESET_PC, q_count=0, out_valid0=out_valid1=0, head/tail pointers=0; queue data is don't-care.
REQ-031 Reset asserted mid-request SHALL abandon the outstanding fetch; the first request after release SHALL be to RESET_PC.

Verification
REQ-032 Reset release, memory answers one cycle after each p_strobe with valid0=valid1=1, deq_count=0 -> requests at 0x0, 0x8, 0x10, 0x18; p_strobe then stays 0 with q_count=8.
REQ-033 Full queue, deq_count=2 for one cycle -> q_count=6, and exactly one new request at 0x20 issues.
REQ-034 Response with instr0_valid=1, instr1_valid=0, raw_instr0=0x00000013 -> q_count +1; out_pc0=fetch address; next request address is +8.
REQ-035 flush=1, flush_pc=0x1003 while in WAIT -> q_count=0; the late response is discarded (DRAIN); the next p_strobe has instr0_addr=0x1000.
REQ-036 Same-cycle push of 2 and deq_count=2 with q_count=3 -> q_count=3; pointer wrap checked across QDEPTH boundary; out_pc ordering monotonic.
REQ-037 rst_n low for one cycle mid-WAIT -> all outputs at reset values immediately; first request after release targets RESET_PC.

Source files
------------

// File: rtl/falco_fetch_queue.sv
// Instruction fetch queue: issues one two-word fetch at a time and buffers the
// returned instructions with their PCs for a decoder that consumes up to two per cycle.
module falco_fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 QDEPTH   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         flush_pc,
  output logic                      p_strobe,
  output logic [ADDR_W-1:0]         instr0_addr,
  input  logic                      resp_ready,
  input  logic [31:0]               raw_instr0,
  input  logic [31:0]               raw_instr1,
  input  logic                      instr0_valid,
  input  logic                      instr1_valid,
  output logic                      out_valid0,
  output logic                      out_valid1,
  output logic [31:0]               out_instr0,
  output logic [31:0]               out_instr1,
  output logic [ADDR_W-1:0]         out_pc0,
  output logic [ADDR_W-1:0]         out_pc1,
  input  logic [1:0]                deq_count,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            q_mem [QDEPTH];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     head, tail, head1, wr1;
  logic [CW-1:0]     free;
  logic [1:0]        deq_eff, pop_n, push_n;
  logic              capture, push0, push1, issue;

  // Free space is judged before this cycle's dequeue, so a granted request
  // always has room for both of its words when the response lands.
  assign free    = CW'(QDEPTH) - q_count;
  assign capture = (state == WAIT) && resp_ready && !flush;
  assign push0   = capture && instr0_valid;
  assign push1   = capture && instr1_valid;
  assign push_n  = {1'b0, push0} + {1'b0, push1};
  assign deq_eff = (deq_count == 2'd3) ? 2'd2 : deq_count;
  assign pop_n   = (CW'(deq_eff) > q_count) ? q_count[1:0] : deq_eff;
  assign head1   = head + PW'(1);
  assign wr1     = push0 ? tail + PW'(1) : tail;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && free >= CW'(2)) begin
          state_nx = WAIT;
          issue    = 1'b1;
        end
      end
      WAIT: begin
        if (flush)           state_nx = resp_ready ? IDLE : DRAIN;
        else if (resp_ready) state_nx = IDLE;
      end
      // The response of a flushed request is still in flight; swallow it.
      DRAIN: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= PC_RST;
      p_strobe    <= 1'b0;
      instr0_addr <= PC_RST;
      q_count     <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state    <= state_nx;
      p_strobe <= issue;
      if (issue) instr0_addr <= fetch_pc;

      if (flush)        fetch_pc <= flush_pc & ALIGN_MASK;
      else if (capture) fetch_pc <= fetch_pc + ADDR_W'(8);

      if (flush) begin
        q_count <= '0;
        head    <= '0;
        tail    <= '0;
      end else begin
        q_count <= q_count + CW'(push_n) - CW'(pop_n);
        head    <= head + PW'(pop_n);
        tail    <= tail + PW'(push_n);
      end
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push0) q_mem[tail] <= '{instr: raw_instr0, pc: fetch_pc};
    if (push1) q_mem[wr1]  <= '{instr: raw_instr1, pc: fetch_pc + ADDR_W'(4)};
  end

  assign out_valid0 = (q_count >= CW'(1));
  assign out_valid1 = (q_count >= CW'(2));
  assign out_instr0 = q_mem[head].instr;
  assign out_pc0    = q_mem[head].pc;
  assign out_instr1 = q_mem[head1].instr;
  assign out_pc1    = q_mem[head1].pc;

endmodule
